// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM instruction: req/ack handshake to a
// variable-latency memory, pipeline stall generation, load return and sticky timeout flag.
module dm_access_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        M_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o
);

  // state | meaning
  // IDLE  | no access in flight; an access in EX/MEM stalls and is launched
  // REQ   | request outstanding; waiting for ack or timeout
  // DONE  | access finished; pipeline advances, M_i still shows the old instruction

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             acc;
  logic             timeout_hit;
  logic             finish;
  logic             stall_c;

  assign acc         = M_i[1] | M_i[0];
  assign timeout_hit = (state == ST_REQ) && !mem_ack_i && (wait_cnt == CNT_LAST);
  assign finish      = (state == ST_REQ) && (mem_ack_i || timeout_hit);

  always_comb begin
    next_state = state;
    stall_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          stall_c    = 1'b1;
          next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (finish) next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Reset gating keeps the pipeline free while rst_i is held, even with an access pending.
  assign stall_o = stall_c & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state         <= next_state;
      mem_req_o     <= (next_state == ST_REQ);
      rdata_valid_o <= finish && !mem_we_o;

      if (state == ST_IDLE && acc) begin
        mem_addr_o  <= addr_i;
        mem_wdata_o <= wdata_i;
        mem_we_o    <= M_i[0];
        wait_cnt    <= '0;
      end else if (state == ST_REQ && !finish) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      // An aborted read returns zero so the load still retires with a defined value.
      if (finish && !mem_we_o) begin
        rdata_o <= mem_ack_i ? mem_rdata_i : '0;
      end

      if (timeout_hit) err_o <= 1'b1;
    end
  end

endmodule
